// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for the sequential ALU.
// Single-cycle ops take 1 cycle; mul WIDTH+1 cycles; div WIDTH+2 cycles; results held until taken.
package seq_alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_SHR  = 5'd8;
    localparam logic [4:0] OP_ROL  = 5'd9;
    localparam logic [4:0] OP_ROR  = 5'd10;
    localparam logic [4:0] OP_NOT  = 5'd11;
    localparam logic [4:0] OP_XOR  = 5'd12;
    localparam logic [4:0] OP_NOR  = 5'd13;
    localparam logic [4:0] OP_NAND = 5'd14;

    localparam int DEF_WIDTH = 32;
    localparam int RES_W     = 2 * DEF_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic ovf;
        logic div0;
        logic illegal;
    } flags_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the control unit (master) and the ALU (slave).
// Both directions use valid/ready; the ALU holds its result until out_ready.
interface seq_alu_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [SEL_W-1:0]     alu_sel;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   alu_out;
    logic                 flag_zero;
    logic                 flag_neg;
    logic                 flag_ovf;
    logic                 flag_div0;
    logic                 flag_illegal;

    modport master (
        output in_valid, alu_sel, a, b, out_ready,
        input  in_ready, out_valid, alu_out,
        input  flag_zero, flag_neg, flag_ovf, flag_div0, flag_illegal
    );

    modport slave (
        input  in_valid, alu_sel, a, b, out_ready,
        output in_ready, out_valid, alu_out,
        output flag_zero, flag_neg, flag_ovf, flag_div0, flag_illegal
    );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative radix-2 Booth multiplier / restoring magnitude divider on one shared accumulator.
// WIDTH iterations after start_i; last_o marks the final one; no backpressure (always runs to end).
module seq_alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] acc_nxt_o
);
    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               ext_q, ext_d, qm1_q, qm1_d, busy_q, busy_d, div_q, div_d;

    logic [WIDTH:0]     hi_ext, m_ext, psum, diff;
    logic [WIDTH-1:0]   rs;

    // Booth partial sum is kept one bit wider so -2^(W-1) multiplicands cannot overflow.
    assign hi_ext = {ext_q, acc_q[2*WIDTH-1:WIDTH]};
    assign m_ext  = {m_q[WIDTH-1], m_q};
    assign rs     = {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]};
    assign diff   = {1'b0, rs} - {1'b0, m_q};

    always_comb begin
        case ({acc_q[0], qm1_q})
            2'b01:   psum = hi_ext + m_ext;
            2'b10:   psum = hi_ext - m_ext;
            default: psum = hi_ext;
        endcase
    end

    always_comb begin
        acc_d  = acc_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        ext_d  = ext_q;
        qm1_d  = qm1_q;
        busy_d = busy_q;
        div_d  = div_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = SHW'(WIDTH - 1);
            div_d  = is_div_i;
            ext_d  = 1'b0;
            qm1_d  = 1'b0;
            if (is_div_i) begin
                m_d   = b_i[WIDTH-1] ? -b_i : b_i;
                acc_d = {{WIDTH{1'b0}}, (a_i[WIDTH-1] ? -a_i : a_i)};
            end else begin
                m_d   = a_i;
                acc_d = {{WIDTH{1'b0}}, b_i};
            end
        end else if (busy_q) begin
            if (div_q) begin
                if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else              acc_d = {rs, acc_q[WIDTH-2:0], 1'b0};
            end else begin
                ext_d = psum[WIDTH];
                qm1_d = acc_q[0];
                acc_d = {psum, acc_q[WIDTH-1:1]};
            end
            if (cnt_q == '0) busy_d = 1'b0;
            else             cnt_d  = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            ext_q  <= 1'b0;
            qm1_q  <= 1'b0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            ext_q  <= ext_d;
            qm1_q  <= qm1_d;
            busy_q <= busy_d;
            div_q  <= div_d;
        end
    end

    assign last_o    = busy_q && (cnt_q == '0);
    assign acc_o     = acc_q;
    assign acc_nxt_o = acc_d;
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: handshake FSM, single-cycle datapath and flags around the mul/div engine.
// Result registered N+1 (simple/div0), N+WIDTH+1 (mul), N+WIDTH+2 (div); held while out_ready=0.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEL_W = 5
) (
    input  logic     clk,
    input  logic     reset,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    flags_t             flags_q, flags_d;
    logic               qneg_q, qneg_d, rneg_q, rneg_d;

    logic               md_start, md_div, md_last;
    logic [2*WIDTH-1:0] md_acc, md_acc_nxt;

    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   sum, dif, sc_lo, quo, rem;
    logic [2*WIDTH-1:0] rot_l, rot_r;
    logic               sc_ovf, sc_ill;

    function automatic flags_t mk_flags(input logic [WIDTH-1:0] lo, input logic ovf,
                                        input logic div0, input logic ill);
        flags_t f;
        f.zero    = (lo == '0);
        f.neg     = lo[WIDTH-1];
        f.ovf     = ovf;
        f.div0    = div0;
        f.illegal = ill;
        return f;
    endfunction

    assign sh    = bus.a[SHW-1:0];
    assign sum   = bus.a + bus.b;
    assign dif   = bus.a - bus.b;
    // Rotates fall out of shifting B concatenated with itself.
    assign rot_l = {bus.b, bus.b} << sh;
    assign rot_r = {bus.b, bus.b} >> sh;

    always_comb begin
        sc_lo  = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        case (bus.alu_sel)
            OP_ADD: begin
                sc_lo  = sum;
                sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo  = dif;
                sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  sc_lo = bus.a & bus.b;
            OP_OR:   sc_lo = bus.a | bus.b;
            OP_XOR:  sc_lo = bus.a ^ bus.b;
            OP_NOR:  sc_lo = ~(bus.a | bus.b);
            OP_NAND: sc_lo = ~(bus.a & bus.b);
            OP_NOT:  sc_lo = ~bus.b;
            OP_SHL:  sc_lo = bus.b << sh;
            OP_SHR:  sc_lo = bus.b >> sh;
            OP_ROL:  sc_lo = rot_l[2*WIDTH-1:WIDTH];
            OP_ROR:  sc_lo = rot_r[WIDTH-1:0];
            OP_MUL, OP_DIV: sc_lo = '0;
            default: sc_ill = 1'b1;
        endcase
    end

    assign quo = qneg_q ? -md_acc[WIDTH-1:0] : md_acc[WIDTH-1:0];
    assign rem = rneg_q ? -md_acc[2*WIDTH-1:WIDTH] : md_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        flags_d  = flags_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        md_start = 1'b0;
        md_div   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.alu_sel == OP_MUL) begin
                        md_start = 1'b1;
                        state_d  = S_MUL;
                    end else if (bus.alu_sel == OP_DIV && bus.b == '0) begin
                        res_d   = {bus.a, {WIDTH{1'b1}}};
                        flags_d = mk_flags({WIDTH{1'b1}}, 1'b0, 1'b1, 1'b0);
                        state_d = S_DONE;
                    end else if (bus.alu_sel == OP_DIV) begin
                        md_start = 1'b1;
                        md_div   = 1'b1;
                        qneg_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        rneg_d   = bus.a[WIDTH-1];
                        state_d  = S_DIV;
                    end else begin
                        res_d   = {{WIDTH{1'b0}}, sc_lo};
                        flags_d = mk_flags(sc_lo, sc_ovf, 1'b0, sc_ill);
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                if (md_last) begin
                    res_d   = md_acc_nxt;
                    flags_d = mk_flags(md_acc_nxt[WIDTH-1:0], 1'b0, 1'b0, 1'b0);
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                if (md_last) state_d = S_FIX;
            end
            S_FIX: begin
                res_d   = {rem, quo};
                flags_d = mk_flags(quo, 1'b0, 1'b0, 1'b0);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    flags_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            flags_q <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .start_i   (md_start),
        .is_div_i  (md_div),
        .a_i       (bus.a),
        .b_i       (bus.b),
        .last_o    (md_last),
        .acc_o     (md_acc),
        .acc_nxt_o (md_acc_nxt)
    );

    assign bus.in_ready     = (state_q == S_IDLE);
    assign bus.out_valid    = (state_q == S_DONE);
    assign bus.alu_out      = res_q;
    assign bus.flag_zero    = flags_q.zero;
    assign bus.flag_neg     = flags_q.neg;
    assign bus.flag_ovf     = flags_q.ovf;
    assign bus.flag_div0    = flags_q.div0;
    assign bus.flag_illegal = flags_q.illegal;
endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed stimulus for seq_alu against an arithmetic reference model.
// Checks result, flags, latency, hold-under-backpressure and reset abort.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W), .SEL_W(5)) bus ();

    seq_alu #(.WIDTH(W), .SEL_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] dut_flags();
        return {bus.flag_zero, bus.flag_neg, bus.flag_ovf, bus.flag_div0, bus.flag_illegal};
    endfunction

    // Reference: flags packed as {zero, neg, ovf, div0, illegal}.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] res, output logic [4:0] fl, output int lat);
        longint     sa  = longint'($signed(a));
        longint     sb  = longint'($signed(b));
        longint     w   = 0;
        logic [31:0] lo = '0;
        logic [31:0] hi = '0;
        logic       ovf = 1'b0;
        logic       d0  = 1'b0;
        logic       ill = 1'b0;
        int         sh  = int'(a[4:0]);
        lat = 1;
        case (op)
            OP_ADD:  begin w = sa + sb; lo = w[31:0]; ovf = (w != longint'($signed(lo))); end
            OP_SUB:  begin w = sa - sb; lo = w[31:0]; ovf = (w != longint'($signed(lo))); end
            OP_AND:  lo = a & b;
            OP_OR:   lo = a | b;
            OP_XOR:  lo = a ^ b;
            OP_NOR:  lo = ~(a | b);
            OP_NAND: lo = ~(a & b);
            OP_NOT:  lo = ~b;
            OP_SHL:  lo = b << sh;
            OP_SHR:  lo = b >> sh;
            OP_ROL:  lo = (sh == 0) ? b : ((b << sh) | (b >> (32 - sh)));
            OP_ROR:  lo = (sh == 0) ? b : ((b >> sh) | (b << (32 - sh)));
            OP_MUL:  begin w = sa * sb; hi = w[63:32]; lo = w[31:0]; lat = 33; end
            OP_DIV: begin
                if (b == 32'd0) begin
                    hi = a; lo = '1; d0 = 1'b1;
                end else begin
                    w  = sa / sb; lo = w[31:0];
                    w  = sa % sb; hi = w[31:0];
                    lat = 34;
                end
            end
            default: ill = 1'b1;
        endcase
        res = {hi, lo};
        fl  = {(lo == 32'd0), lo[31], ovf, d0, ill};
    endfunction

    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        logic [63:0] er;
        logic [4:0]  ef;
        int          el;
        int          k;
        model(op, a, b, er, ef, el);
        @(negedge clk);
        check("in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.alu_sel   = op;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            bus.in_valid = 1'b0;
        end while (!bus.out_valid && k < 200);
        check("latency", 64'(k), 64'(el));
        check("alu_out", bus.alu_out, er);
        check("flags", 64'(dut_flags()), 64'(ef));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                bus.in_valid = 1'b1;
                bus.alu_sel  = OP_ADD;
                bus.a        = 32'(i);
                bus.b        = 32'd1;
                @(negedge clk);
                check("hold_vld", 64'(bus.out_valid), 64'd1);
                check("hold_rdy", 64'(bus.in_ready), 64'd0);
                check("hold_out", bus.alu_out, er);
                check("hold_flags", 64'(dut_flags()), 64'(ef));
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        check("drain_vld", 64'(bus.out_valid), 64'd0);
        check("drain_rdy", 64'(bus.in_ready), 64'd1);
        check("drain_flags", 64'(dut_flags()), 64'd0);
    endtask

    logic [4:0] op_tab [17] = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_SHL, OP_SHR,
                                OP_ROL, OP_ROR, OP_NOT, OP_XOR, OP_NOR, OP_NAND, 5'd3, 5'd20, 5'd31};

    initial begin
        logic [31:0] ra, rb;
        logic [4:0]  rop;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.alu_sel   = '0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", 64'(bus.in_ready), 64'd1);
        check("rst_vld", 64'(bus.out_valid), 64'd0);
        check("rst_out", bus.alu_out, 64'd0);
        check("rst_flags", 64'(dut_flags()), 64'd0);
        reset = 1'b0;

        do_op(OP_ADD, 32'h7FFFFFFF, 32'd1, 0);
        do_op(OP_MUL, -32'sd3, 32'd7, 0);
        do_op(OP_MUL, 32'h80000000, 32'h80000000, 0);
        do_op(OP_DIV, -32'sd7, 32'd2, 0);
        do_op(OP_DIV, 32'd5, 32'd0, 0);
        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
        do_op(OP_ROL, 32'd4, 32'h80000001, 0);
        do_op(OP_SHR, 32'd0, 32'h10, 0);
        do_op(OP_SUB, 32'h80000000, 32'd1, 0);
        do_op(5'd3, 32'd9, 32'd9, 0);
        do_op(OP_XOR, 32'h1234, 32'h1234, 5);
        do_op(OP_MUL, 32'd123, -32'sd45, 3);

        // Reset while a multiply is in flight.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.alu_sel  = OP_MUL;
        bus.a        = -32'sd3;
        bus.b        = 32'd7;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort_vld", 64'(bus.out_valid), 64'd0);
        check("abort_rdy", 64'(bus.in_ready), 64'd1);
        check("abort_out", bus.alu_out, 64'd0);
        reset = 1'b0;
        do_op(OP_ADD, 32'd2, 32'd3, 0);

        for (int i = 0; i < 60; i++) begin
            rop = op_tab[$urandom_range(0, 16)];
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                1: rb = 32'd0;
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op(rop, ra, rb, (i % 7 == 0) ? 2 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
